// File: rtl/demux1x8_collect.sv
// demux1x8_collect: reassembles a bit-serial stream (bit + position select) into a word on a valid/ready output.
module demux1x8_collect #(
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             sync,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             seq_err,
  output logic             overrun
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   exp_q, exp_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d, result_q, result_d;
  logic               result_valid_q, result_valid_d, seq_err_q, seq_err_d, overrun_q, overrun_d;
  logic               start, last;
  assign start = din_valid && sync && sel == '0;
  assign last  = sel == SEL_W'(WIDTH - 1);
  always_comb begin
    state_d        = state_q;
    exp_d          = exp_q;
    shadow_d       = shadow_q;
    result_d       = result_q;
    result_valid_d = result_valid_q && !result_ready;
    seq_err_d      = 1'b0;
    overrun_d      = 1'b0;
    if (start) begin
      seq_err_d   = state_q == COLLECT;
      shadow_d[0] = din;
      exp_d       = SEL_W'(1);
      state_d     = COLLECT;
    end else if (din_valid && state_q == IDLE) begin
      seq_err_d = sync;
    end else if (din_valid) begin
      if (!sync && sel == exp_q) begin
        shadow_d[sel] = din;
        exp_d         = exp_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          // Slot is free if empty or being drained this same cycle.
          if (!result_valid_q || result_ready) begin
            result_d       = {din, shadow_q[WIDTH-2:0]};
            result_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end else begin
        seq_err_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      exp_q          <= '0;
      shadow_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      seq_err_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      exp_q          <= exp_d;
      shadow_q       <= shadow_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      seq_err_q      <= seq_err_d;
      overrun_q      <= overrun_d;
    end
  end
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign seq_err      = seq_err_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_demux1x8_collect.sv
// tb_demux1x8_collect: directed stimulus with a queue scoreboard checked by a decoupled output monitor.
module tb_demux1x8_collect;
  logic       clk = 0, rst_n = 0, din = 0, din_valid = 0, sync = 0, result_ready = 0;
  logic [2:0] sel = 0;
  logic [7:0] result;
  logic       result_valid, seq_err, overrun;
  int         checks = 0, errors = 0, seq_cnt = 0, ov_cnt = 0, both_cnt = 0;
  int         seq_base, ov_base;
  logic [7:0] exp_q[$];

  demux1x8_collect dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sel(sel), .sync(sync),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .seq_err(seq_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (seq_err) seq_cnt++;
    if (overrun) ov_cnt++;
    if (seq_err && overrun) both_cnt++;
    if (rst_n && result_valid && result_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word: got %h, required none (unexpected word)", result);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL word: got %h, required %h", result, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic d, input logic [2:0] s, input logic sy);
    din = d; sel = s; sync = sy; din_valid = 1;
    idle(1);
    din_valid = 0; sync = 0;
  endtask

  task automatic word(input logic [7:0] w, input int gap);
    for (int i = 0; i < 8; i++) begin
      beat(w[i], 3'(i), i == 0);
      if (gap > 0 && (i == 2 || i == 5)) idle(gap);
    end
  endtask

  initial begin
    #2;
    chk("reset result", int'(result), 0);
    chk("reset valid", int'(result_valid), 0);
    chk("reset seq_err", int'(seq_err), 0);
    chk("reset overrun", int'(overrun), 0);
    idle(2);
    rst_n = 1;
    result_ready = 1;
    idle(1);

    exp_q.push_back(8'hAA);
    word(8'hAA, 0);
    chk("basic valid latency", int'(result_valid), 1);
    chk("basic result", int'(result), 8'hAA);
    idle(2);
    chk("basic no seq_err", seq_cnt, 0);
    chk("basic no overrun", ov_cnt, 0);

    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    word(8'h3C, 0);
    word(8'hC3, 2);
    chk("b2b last result", int'(result), 8'hC3);
    idle(2);
    chk("b2b drained", exp_q.size(), 0);

    seq_base = seq_cnt;
    beat(1, 3'd0, 1);
    beat(0, 3'd1, 0);
    beat(1, 3'd3, 0);
    chk("ooo seq_err pulse", int'(seq_err), 1);
    for (int i = 4; i < 8; i++) beat(1, 3'(i), 0);
    chk("ooo seq_err one cycle", int'(seq_err), 0);
    idle(2);
    chk("ooo seq_err count", seq_cnt - seq_base, 1);
    chk("ooo no valid", int'(result_valid), 0);

    seq_base = seq_cnt;
    for (int i = 0; i < 5; i++) beat(1, 3'(i), i == 0);
    exp_q.push_back(8'h5A);
    word(8'h5A, 0);
    idle(2);
    chk("restart seq_err count", seq_cnt - seq_base, 1);
    chk("restart drained", exp_q.size(), 0);

    ov_base = ov_cnt;
    result_ready = 0;
    exp_q.push_back(8'h11);
    word(8'h11, 0);
    word(8'h22, 0);
    chk("bp overrun pulse", int'(overrun), 1);
    chk("bp result held", int'(result), 8'h11);
    idle(2);
    chk("bp overrun count", ov_cnt - ov_base, 1);
    chk("bp valid held", int'(result_valid), 1);
    result_ready = 1;
    idle(1);
    chk("bp valid drop", int'(result_valid), 0);
    chk("bp drained", exp_q.size(), 0);

    result_ready = 0;
    word(8'h33, 0);
    for (int i = 0; i < 4; i++) beat(1, 3'(i), i == 0);
    chk("pre-reset valid", int'(result_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("async reset result", int'(result), 0);
    chk("async reset valid", int'(result_valid), 0);
    idle(2);
    rst_n = 1;
    result_ready = 1;
    for (int i = 4; i < 8; i++) beat(1, 3'(i), 0);
    chk("no sync after reset", int'(result_valid), 0);
    exp_q.push_back(8'hFF);
    word(8'hFF, 0);
    chk("post-reset result", int'(result), 8'hFF);
    idle(3);
    chk("final drained", exp_q.size(), 0);
    chk("total seq_err", seq_cnt, 2);
    chk("total overrun", ov_cnt, 1);
    chk("never both pulses", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux1x8_collect.md
# demux1x8_collect

Sequential 1-to-8 demultiplexer that reassembles a byte from a bit-serial stream. The transmitting side drives one data bit per beat together with its 3-bit select (bit position 000..111) and a start marker; this block steers each bit into the addressed position of a shadow register. When all eight positions have arrived in order, it presents the byte on a valid/ready output. It is the receive end of the 8:1 mux serial path, using the same `sel` encoding as the existing mux blocks.

## Interface
- `WIDTH`, default 8: number of bit positions, i.e. the output byte width. Must be a power of two ≥ 2. `SEL_W = $clog2(WIDTH)` is derived and not overridable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din`/`sel`/`sync` are meaningful this cycle.
- `sel`  in  `SEL_W`  bit position of `din` in the output word.
- `sync`  in  1  marks the first bit of a word; legal only with `sel == 0`.
- `result`  out  `WIDTH`  assembled word; stable while `result_valid` is high.
- `result_valid`  out  1  `result` holds an unconsumed word.
- `result_ready`  in  1  consumer accepts `result` when `result_valid && result_ready`.
- `seq_err`  out  1  one-cycle pulse: out-of-order `sel` or `sync` with nonzero `sel`.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped because the output was occupied.

## Operation
- State machine: `IDLE`, `COLLECT`. Internal state is the shadow register (`WIDTH` bits) and the expected position counter `exp` (`SEL_W` bits).
- **`IDLE`**
  - On `din_valid && sync && sel == 0`: write `shadow[0] = din`, set `exp = 1`, go to `COLLECT`.
  - On `din_valid && sync && sel != 0`: pulse `seq_err`, stay in `IDLE`.
  - `din_valid` without `sync` is silently ignored.
- **`COLLECT`**, on `din_valid`:
  - `sync && sel == 0`: restart. Pulse `seq_err` (partial word abandoned), write `shadow[0]`, set `exp = 1`.
  - `sel == exp` and no `sync`: write `shadow[sel] = din`, increment `exp`.
  - Any other case: pulse `seq_err`, discard the partial word, go to `IDLE`.
  - `din_valid` low: hold all state; gaps of any length are allowed.
- **Completion** (accepted bit with `sel == WIDTH-1`):
  - If the output slot is free (`!result_valid`, or `result_valid && result_ready` in the same cycle), load `result = {din, shadow[WIDTH-2:0]}`, set `result_valid = 1`, go to `IDLE`.
  - Otherwise pulse `overrun`, leave `result` and `result_valid` unchanged, drop the word, go to `IDLE`.
- `result_valid` clears on `result_valid && result_ready` unless a new word loads in the same cycle. `result` changes only on a load.
- Unwritten shadow bits never reach `result`. The shadow register need not be cleared between words.
- `seq_err` and `overrun` never assert in the same cycle.

## Timing
- Reset values: `result = 0`, `result_valid = 0`, `seq_err = 0`, `overrun = 0`, state `IDLE`, `exp = 0`, shadow `= 0`.
- Latency: `result_valid` rises on the first rising edge after the cycle carrying `sel == WIDTH-1`, i.e. 1 cycle.
- Sustained throughput: one word per `WIDTH` valid beats. A `sync` beat may immediately follow a completion beat with no bubble.
- With `result_ready` held high, back-to-back words never overrun.
- `seq_err` and `overrun` are registered and high for exactly one cycle, the cycle after the offending beat.
- Reset asserted mid-word or with `result_valid` high forces all reset values immediately, with no dependence on `clk`. The first word after reset requires a fresh `sync`.
- All inputs are sampled only on the rising edge of `clk`. There are no combinational paths from input to output.

## Test plan
- **Basic word:** reset; send `din` bits of 8'b10101010 LSB-first with `sel` 000..111, `sync` on beat 0, `result_ready = 1` → `result = 8'hAA`, `result_valid` high one cycle after the `sel = 111` beat, no error pulses.
- **Back-to-back with gaps:** send 8'h3C then 8'hC3 back-to-back, with 2-cycle `din_valid` gaps inside the second word → `result` = 8'h3C, then 8'hC3; `exp` holds across the gaps.
- **Out-of-order select:** `sync` at `sel = 000`, then `sel = 001`, then `sel = 011` → `seq_err` pulses once, block returns to `IDLE`; subsequent non-`sync` beats are ignored and `result_valid` stays 0.
- **Restart mid-word:** `sync` after 5 bits, followed by a full 8'h5A → one `seq_err` pulse, then `result = 8'h5A`.
- **Backpressure:** `result_ready = 0`; send 8'h11 then 8'h22 → `result` stays 8'h11, `overrun` pulses once after the 8'h22 completion beat; raise `result_ready` → `result_valid` drops.
- **Reset mid-operation:** drop `rst_n` asynchronously after 4 bits with `result_valid` high → all outputs 0 immediately; a following full word 8'hFF is assembled correctly.
